// File: rtl/mv_block_sequencer.sv
// Raster-order MV fetcher for the MVF engine: READ -> WAIT_DATA -> ISSUE -> WAIT_NXT per block, 4-cycle minimum period.
// Backpressure: holds in WAIT_NXT until Nxt_block_sig; enable=0 freezes all states except WAIT_DATA.
module mv_block_sequencer #(
   parameter int DIM_W   = 8,
   parameter int MV_W    = 8,
   parameter int MADDR_W = 16
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                enable,
   input  logic                start,
   input  logic [DIM_W-1:0]    height,
   input  logic [DIM_W-1:0]    width,
   output logic                mem_rd,
   output logic [MADDR_W-1:0]  mem_addr,
   input  logic [2*MV_W-1:0]   mem_rdata,
   output logic                Vector_sig,
   output logic [MV_W-1:0]     mv_x,
   output logic [MV_W-1:0]     mv_y,
   output logic [DIM_W-1:0]    addr_x,
   output logic [DIM_W-1:0]    addr_y,
   input  logic                Nxt_block_sig,
   output logic                busy,
   output logic                frame_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT_DATA, S_ISSUE, S_WAIT_NXT, S_DONE
   } state_t;

   state_t            state;
   logic [DIM_W-1:0]  wid_q;
   logic [DIM_W-1:0]  hgt_q;
   logic [DIM_W-1:0]  x_cnt;
   logic [DIM_W-1:0]  y_cnt;
   logic              last_blk;
   logic              last_col;

   assign last_col = (x_cnt == wid_q - DIM_W'(1));
   assign last_blk = last_col && (y_cnt == hgt_q - DIM_W'(1));

   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= S_IDLE;
         wid_q      <= '0;
         hgt_q      <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         Vector_sig <= 1'b0;
         mv_x       <= '0;
         mv_y       <= '0;
         addr_x     <= '0;
         addr_y     <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && enable) begin
                  wid_q    <= width;
                  hgt_q    <= height;
                  x_cnt    <= '0;
                  y_cnt    <= '0;
                  mem_addr <= '0;
                  busy     <= 1'b1;
                  // An empty frame arms its done pulse one cycle after entering DONE.
                  if (width == '0 || height == '0) begin
                     state <= S_DONE;
                  end else begin
                     state  <= S_READ;
                     mem_rd <= 1'b1;
                  end
               end
            end
            // Strobe states: once the strobe has been high for a cycle the action is
            // done and the FSM moves on; a frozen entry re-arms the strobe on re-enable.
            S_READ: begin
               if (mem_rd) begin
                  mem_rd <= 1'b0;
                  state  <= S_WAIT_DATA;
               end else if (enable) begin
                  mem_rd <= 1'b1;
               end
            end
            S_WAIT_DATA: begin
               mv_x       <= mem_rdata[2*MV_W-1:MV_W];
               mv_y       <= mem_rdata[MV_W-1:0];
               addr_x     <= x_cnt;
               addr_y     <= y_cnt;
               Vector_sig <= enable;
               state      <= S_ISSUE;
            end
            S_ISSUE: begin
               if (Vector_sig) begin
                  Vector_sig <= 1'b0;
                  state      <= S_WAIT_NXT;
               end else if (enable) begin
                  Vector_sig <= 1'b1;
               end
            end
            S_WAIT_NXT: begin
               if (enable && Nxt_block_sig) begin
                  if (last_blk) begin
                     state      <= S_DONE;
                     frame_done <= 1'b1;
                  end else begin
                     if (last_col) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + DIM_W'(1);
                     end else begin
                        x_cnt <= x_cnt + DIM_W'(1);
                     end
                     mem_addr <= mem_addr + MADDR_W'(1);
                     mem_rd   <= 1'b1;
                     state    <= S_READ;
                  end
               end
            end
            S_DONE: begin
               if (frame_done) begin
                  frame_done <= 1'b0;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end else if (enable) begin
                  frame_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mv_block_sequencer.sv
// Directed bench for mv_block_sequencer: raster order, empty frame, latency, enable freeze, reset, ignored inputs.
module tb_mv_block_sequencer;

   logic        CLK = 1'b0;
   logic        reset, enable, start;
   logic [7:0]  height, width;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata = '0;
   logic        Vector_sig;
   logic [7:0]  mv_x, mv_y, addr_x, addr_y;
   logic        Nxt_block_sig;
   logic        busy, frame_done;

   logic        ack_lvl = 1'b0;
   logic        auto_en = 1'b0;
   logic        vs_d1 = 1'b0;
   logic        auto_ack = 1'b0;

   int          n_chk = 0;
   int          n_bad = 0;
   int          fd_cnt = 0;
   logic [31:0] vq[$];
   logic [15:0] aq[$];

   always #5 CLK = ~CLK;

   mv_block_sequencer dut (
      .CLK(CLK), .reset(reset), .enable(enable), .start(start),
      .height(height), .width(width), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .Vector_sig(Vector_sig), .mv_x(mv_x), .mv_y(mv_y),
      .addr_x(addr_x), .addr_y(addr_y), .Nxt_block_sig(Nxt_block_sig),
      .busy(busy), .frame_done(frame_done)
   );

   // MV memory: one-cycle read latency, data = 16'h0100 + address
   always @(posedge CLK) begin
      if (mem_rd) mem_rdata <= 16'h0100 + mem_addr;
   end

   // Engine model: ack pulse two cycles after each Vector_sig
   always @(posedge CLK) begin
      vs_d1    <= Vector_sig;
      auto_ack <= vs_d1;
   end
   assign Nxt_block_sig = (auto_en & auto_ack) | ack_lvl;

   always @(negedge CLK) begin
      if (!reset) begin
         if (Vector_sig) vq.push_back({mv_x, mv_y, addr_x, addr_y});
         if (mem_rd)     aq.push_back(mem_addr);
         if (frame_done) fd_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_frame(input int w, input int h);
      width  = 8'(w);
      height = 8'(h);
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int f0 = fd_cnt;
      int n  = 0;
      while (fd_cnt == f0 && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
   endtask

   task automatic check_raster(input string tag, input int bv, input int ba, input int w, input int h);
      logic [31:0] e;
      chk({tag, "_nvec"}, 32'(vq.size() - bv), 32'(w * h));
      chk({tag, "_nrd"}, 32'(aq.size() - ba), 32'(w * h));
      for (int i = 0; i < w * h; i++) begin
         if (bv + i < vq.size()) begin
            e = vq[bv + i];
            chk($sformatf("%s_ax%0d", tag, i), 32'(e[15:8]), 32'(i % w));
            chk($sformatf("%s_ay%0d", tag, i), 32'(e[7:0]), 32'(i / w));
            chk($sformatf("%s_mvx%0d", tag, i), 32'(e[31:24]), 32'h01);
            chk($sformatf("%s_mvy%0d", tag, i), 32'(e[23:16]), 32'(i));
         end
         if (ba + i < aq.size())
            chk($sformatf("%s_maddr%0d", tag, i), 32'(aq[ba + i]), 32'(i));
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
      chk({tag, "_vsig"}, 32'(Vector_sig), 32'd0);
      chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
      chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mv"}, 32'({mv_x, mv_y}), 32'd0);
      chk({tag, "_addr"}, 32'({addr_x, addr_y}), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bv, ba, bf;
      reset = 1'b1; enable = 1'b1; start = 1'b0; width = '0; height = '0;
      repeat (3) tick();
      check_all_zero("rst");
      reset = 1'b0;
      tick();

      // 1: 3x2 frame, engine acks two cycles after each strobe
      auto_en = 1'b1;
      bv = vq.size(); ba = aq.size(); bf = fd_cnt;
      start_frame(3, 2);
      wait_done("t1", 200);
      check_raster("t1", bv, ba, 3, 2);
      chk("t1_fdcnt", 32'(fd_cnt - bf), 32'd1);
      chk("t1_busy_after", 32'(busy), 32'd0);
      auto_en = 1'b0;
      tick();

      // 2: zero width -> straight to DONE
      bv = vq.size(); ba = aq.size();
      start_frame(0, 5);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_fd_early", 32'(frame_done), 32'd0);
      tick();
      chk("t2_fd", 32'(frame_done), 32'd1);
      tick();
      chk("t2_fd_off", 32'(frame_done), 32'd0);
      chk("t2_busy_after", 32'(busy), 32'd0);
      chk("t2_nvec", 32'(vq.size() - bv), 32'd0);
      chk("t2_nrd", 32'(aq.size() - ba), 32'd0);

      // 3: 1x1 with ack tied high, latency check
      ack_lvl = 1'b1;
      start_frame(1, 1);
      chk("t3_mem_rd", 32'(mem_rd), 32'd1);
      tick(); tick();
      chk("t3_vsig", 32'(Vector_sig), 32'd1);
      chk("t3_addr", 32'({addr_x, addr_y}), 32'd0);
      tick();
      chk("t3_vsig_off", 32'(Vector_sig), 32'd0);
      tick();
      chk("t3_fd", 32'(frame_done), 32'd1);
      tick();
      chk("t3_busy_after", 32'(busy), 32'd0);

      // 4: 2x2, enable dropped for 5 cycles while waiting in WAIT_NXT with ack high
      bv = vq.size(); ba = aq.size();
      start_frame(2, 2);
      tick(); tick();
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t4_frz_rd%0d", i), 32'(mem_rd), 32'd0);
         chk($sformatf("t4_frz_vs%0d", i), 32'(Vector_sig), 32'd0);
      end
      chk("t4_frz_busy", 32'(busy), 32'd1);
      enable = 1'b1;
      tick();
      chk("t4_resume_rd", 32'(mem_rd), 32'd1);
      chk("t4_resume_addr", 32'(mem_addr), 32'd1);
      wait_done("t4", 100);
      check_raster("t4", bv, ba, 2, 2);
      ack_lvl = 1'b0;
      tick();

      // 5: reset during block (1,0) of a 3x3 frame, then a 1x1 frame
      ack_lvl = 1'b1;
      start_frame(3, 3);
      repeat (6) tick();
      chk("t5_pre_vsig", 32'(Vector_sig), 32'd1);
      chk("t5_pre_ax", 32'(addr_x), 32'd1);
      bf = fd_cnt;
      reset = 1'b1;
      tick();
      check_all_zero("t5_rst");
      reset = 1'b0;
      tick();
      bv = vq.size(); ba = aq.size();
      start_frame(1, 1);
      wait_done("t5", 50);
      check_raster("t5", bv, ba, 1, 1);
      chk("t5_fdcnt", 32'(fd_cnt - bf), 32'd1);
      ack_lvl = 1'b0;
      tick();

      // 6: start/width/height changes and an ISSUE-cycle ack during a 3x2 frame
      auto_en = 1'b1;
      bv = vq.size(); ba = aq.size(); bf = fd_cnt;
      start_frame(3, 2);
      start = 1'b1; width = 8'd1; height = 8'd1;
      tick();
      start = 1'b0; width = 8'd7; height = 8'd9;
      tick();
      chk("t6_issue", 32'(Vector_sig), 32'd1);
      ack_lvl = 1'b1;
      tick();
      ack_lvl = 1'b0;
      wait_done("t6", 200);
      check_raster("t6", bv, ba, 3, 2);
      chk("t6_fdcnt", 32'(fd_cnt - bf), 32'd1);
      tick(); tick();
      chk("t6_busy_after", 32'(busy), 32'd0);
      auto_en = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
